tt_um_nasser_hadi_toggle_decoder: RTL and testbench
===================================================

Name: tt_um_nasser_hadi_toggle_decoder

Overview:
- Receive-side companion to the team's T flip-flop tile.
- Takes a toggle-encoded line, where each level change is one event, and synchronises and debounces it.
- Regenerates a one-cycle event pulse per qualified toggle and counts events in an 8-bit counter.
- Flags line inactivity.
- Sits as a standalone TinyTapeout tile; the toggle line arrives from an external source or another tile.

Parameters:
- SYNC_STAGES, 2: flops in the input synchroniser (legal values 2..3).
- DEBOUNCE_CYCLES, 4: consecutive cycles a changed level must persist before it is accepted (legal values 1..15).
- TIMEOUT_CYCLES, 255: cycles without a qualified toggle before the idle flag asserts (legal values 1..65535).

Ports:
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- ena  input  1  tile enable; 0 freezes decoder state.
- ui_in  input  8  [0] toggle line (async); [1] clear (sync, active-high); [2] saturate mode (1 = saturate, 0 = wrap); [7:3] unused.
- uo_out  output  8  [0] event pulse; [1] filtered level; [2] overflow sticky; [3] idle flag; [7:4] = 0.
- uio_in  input  8  unused.
- uio_out  output  8  event count[7:0].
- uio_oe  output  8  constant 8'hFF.
- One clock; reset is asynchronous and active-low (clk, rst_n).

Behaviour:
- Reset (rst_n=0, async): sync flops=0; filtered level=0; debounce count=0; state=IDLE; pulse=0; event count=0; overflow=0; timeout count=0; idle=0. Outputs reflect these immediately.
- Synchroniser: ui_in[0] passes through SYNC_STAGES flops to give sync_q. It runs only when ena=1 (frozen like other state).
- Debounce FSM, state IDLE:
  - If sync_q == level: stay, with debounce count=0.
  - If sync_q != level: go to QUALIFY with count=1.
  - Exception: if DEBOUNCE_CYCLES=1, accept immediately (see accept).
- Debounce FSM, state QUALIFY:
  - If sync_q == level (glitch): go to IDLE, count=0, no pulse.
  - Else, if count == DEBOUNCE_CYCLES-1: accept and go to IDLE.
  - Else: count+1.
- Accept action: level <= sync_q and pulse <= 1 on the same edge. Pulse is high for exactly one cycle; back-to-back accepts are impossible while DEBOUNCE_CYCLES >= 1.
- Latency: input stable before edge 1 changes gives pulse and level change visible after edge SYNC_STAGES+DEBOUNCE_CYCLES. Defaults give edge 6.
- Event counter, on pulse:
  - Count below 255: increment.
  - Count = 255 with saturate=1: hold 255 and set overflow.
  - Count = 255 with saturate=0: wrap to 0 and set overflow.
  - Overflow is sticky.
  - Mode is sampled on the incrementing edge.
- Clear (ui_in[1]=1, ena=1): next edge sets count=0, overflow=0, idle=0, timeout count=0.
  - Clear has priority over a simultaneous increment: count ends at 0, but pulse still emits.
  - Clear does not affect the sync, debounce or level state.
- Idle timer:
  - 16-bit timeout counter resets to 0 on every pulse or clear; otherwise it increments, saturating at TIMEOUT_CYCLES.
  - idle=1 when the counter reaches TIMEOUT_CYCLES; it clears on the next pulse or clear.
  - Timer starts at reset release.
- ena=0: all registers hold, except pulse, which is forced to 0 on the next edge. A debounce in progress resumes where it left off when ena returns to 1.
- Reset mid-QUALIFY: qualification is abandoned, and no pulse is emitted after release unless the line again differs from level 0.

Decomposition:
- Package tt_toggle_pkg: enum dec_state_t {IDLE, QUALIFY}; localparams CNT_W=8, TMO_W=16, DBC_W=4; ui/uo bit-index constants.
- Sub-module toggle_debounce: synchroniser plus debounce FSM; outputs level and pulse.
- Top module: counter, overflow, idle timer, pin mapping.

Test Plan:
- Reset, then hold ui_in[0]=0 for 20 cycles -> uo_out=0x00, uio_out=0x00, uio_oe=0xFF, no pulse.
- Set ui_in[0] 0->1 before edge 1 (defaults) -> uo_out[0]=1 only after edge 6, uo_out[1]=1 from edge 6 on, uio_out=0x01.
- 3-cycle glitch 0->1->0 with DEBOUNCE_CYCLES=4 -> no pulse, level stays 0, count stays 0.
- 256 qualified toggles with saturate=0 -> count 0x00 with overflow=1. Repeat with saturate=1 -> count 0xFF, overflow=1. Assert clear -> count 0, overflow 0.
- With TIMEOUT_CYCLES=10, no toggles after reset -> idle=1 from cycle 10 on. One toggle -> idle=0 on the pulse edge.
- Clear asserted on the same edge as a pulse -> uo_out[0]=1 that cycle, uio_out=0x00. Drop ena mid-QUALIFY for 5 cycles -> pulse delayed exactly 5 cycles.

Source files
------------

// File: rtl/tt_toggle_pkg.sv
// Shared types and constants for the toggle decoder tile.
// Holds the debounce FSM state encoding, counter widths and pin bit indices.
// Imported by toggle_debounce and tt_um_nasser_hadi_toggle_decoder.
package tt_toggle_pkg;

  typedef enum logic {
    IDLE    = 1'b0,
    QUALIFY = 1'b1
  } dec_state_t;

  localparam int CNT_W = 8;   // event counter width
  localparam int TMO_W = 16;  // idle timer width
  localparam int DBC_W = 4;   // debounce counter width (DEBOUNCE_CYCLES <= 15)

  // ui_in bit positions
  localparam int UI_LINE  = 0;
  localparam int UI_CLEAR = 1;
  localparam int UI_SAT   = 2;

  // uo_out bit positions
  localparam int UO_PULSE = 0;
  localparam int UO_LEVEL = 1;
  localparam int UO_OVF   = 2;
  localparam int UO_IDLE  = 3;

endpackage

// File: rtl/toggle_debounce.sv
// Synchronises an async toggle line and qualifies each level change.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges from line change to pulse/level.
// No backpressure: ena=0 freezes all state and forces pulse low next edge.
// Ports: clk, rst_n, ena, line (async in); level (filtered), pulse (1-cycle),
//        accept (combinational strobe: pulse/level update on the coming edge).
module toggle_debounce
  import tt_toggle_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic ena,
  input  logic line,
  output logic level,
  output logic pulse,
  output logic accept
);

  localparam logic [DBC_W-1:0] DBC_LAST = DBC_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_ff;
  logic                   sync_q;
  dec_state_t             state;
  logic [DBC_W-1:0]       dbc_cnt;

  assign sync_q = sync_ff[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_ff <= '0;
    end else if (ena) begin
      sync_ff <= {sync_ff[SYNC_STAGES-2:0], line};
    end
  end

  // Accept fires when the differing level has persisted long enough. With a
  // one-cycle debounce the first differing sample is accepted from IDLE.
  // Exported so the counters update on the same edge the pulse rises.
  always_comb begin
    accept = 1'b0;
    if (ena && (sync_q != level)) begin
      if (state == IDLE) accept = (DEBOUNCE_CYCLES == 1);
      else               accept = (dbc_cnt == DBC_LAST);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dbc_cnt <= '0;
      level   <= 1'b0;
      pulse   <= 1'b0;
    end else begin
      pulse <= 1'b0;
      if (ena) begin
        if (accept) begin
          level   <= sync_q;
          pulse   <= 1'b1;
          state   <= IDLE;
          dbc_cnt <= '0;
        end else if (sync_q == level) begin
          // Matching level: either quiet line or a glitch that reverted.
          state   <= IDLE;
          dbc_cnt <= '0;
        end else if (state == IDLE) begin
          state   <= QUALIFY;
          dbc_cnt <= DBC_W'(1);
        end else begin
          dbc_cnt <= dbc_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/tt_um_nasser_hadi_toggle_decoder.sv
// Toggle-line decoder tile: debounced event pulse, 8-bit event count, idle flag.
// Latency: SYNC_STAGES + DEBOUNCE_CYCLES edges; count updates with the pulse.
// No backpressure: ena=0 holds all state (pulse drops); clear wins over increment.
// Ports: ui_in[0] line, [1] clear, [2] saturate; uo_out[0] pulse, [1] level,
//        [2] overflow, [3] idle; uio_out event count; uio_oe all outputs.
module tt_um_nasser_hadi_toggle_decoder
  import tt_toggle_pkg::*;
#(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int TIMEOUT_CYCLES  = 255
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(TIMEOUT_CYCLES);

  logic             level;
  logic             pulse;
  logic             accept;
  logic             clear;
  logic             sat_mode;
  logic [CNT_W-1:0] evt_cnt;
  logic             ovf;
  logic             idle;
  logic [TMO_W-1:0] tmo_cnt;
  logic [TMO_W-1:0] tmo_nxt;
  logic             unused;

  assign clear    = ui_in[UI_CLEAR];
  assign sat_mode = ui_in[UI_SAT];
  assign unused   = &{1'b0, ui_in[7:3], uio_in};

  toggle_debounce #(
    .SYNC_STAGES    (SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk   (clk),
    .rst_n (rst_n),
    .ena   (ena),
    .line  (ui_in[UI_LINE]),
    .level (level),
    .pulse (pulse),
    .accept(accept)
  );

  // Idle timer saturates at the timeout so idle stays asserted.
  assign tmo_nxt = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      evt_cnt <= '0;
      ovf     <= 1'b0;
      tmo_cnt <= '0;
      idle    <= 1'b0;
    end else if (ena) begin
      if (clear) begin
        evt_cnt <= '0;
        ovf     <= 1'b0;
        tmo_cnt <= '0;
        idle    <= 1'b0;
      end else if (accept) begin
        tmo_cnt <= '0;
        idle    <= 1'b0;
        if (evt_cnt == '1) begin
          ovf     <= 1'b1;
          evt_cnt <= sat_mode ? evt_cnt : '0;
        end else begin
          evt_cnt <= evt_cnt + 1'b1;
        end
      end else begin
        tmo_cnt <= tmo_nxt;
        idle    <= (tmo_nxt == TMO_MAX);
      end
    end
  end

  always_comb begin
    uo_out           = '0;
    uo_out[UO_PULSE] = pulse;
    uo_out[UO_LEVEL] = level;
    uo_out[UO_OVF]   = ovf;
    uo_out[UO_IDLE]  = idle;
  end

  assign uio_out = evt_cnt;
  assign uio_oe  = 8'hFF;

endmodule

// File: tb/tb_tt_um_nasser_hadi_toggle_decoder.sv
module tb_tt_um_nasser_hadi_toggle_decoder;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b1;
  logic       line = 1'b0;
  logic       clr = 1'b0;
  logic       sat = 1'b0;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in = 8'h00;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  typedef struct {
    int         at_cyc;
    logic [7:0] cnt;
    logic [7:0] uo;
  } exp_t;
  exp_t exp_q[$];

  // bench model
  logic       m_level = 1'b0;
  logic [7:0] m_cnt = 8'h00;
  logic       m_ovf = 1'b0;

  assign ui_in = {5'b0, sat, clr, line};

  tt_um_nasser_hadi_toggle_decoder #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(4),
    .TIMEOUT_CYCLES (10)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .ena    (ena),
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every pulse seen must match the next queued expectation.
  always @(negedge clk) begin
    if (rst_n && uo_out[0] === 1'b1) begin
      if (exp_q.size() == 0) begin
        chk("spurious_pulse", 16'(uo_out), 16'h0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("pulse_cycle", 16'(cyc), 16'(e.at_cyc));
        chk("pulse_count", 16'(uio_out), 16'(e.cnt));
        chk("pulse_uo", 16'(uo_out), 16'(e.uo));
      end
    end
  end

  // One qualified toggle. ena_off>0 drops ena mid-QUALIFY for that many
  // cycles; clr_at_pulse asserts clear on the edge where the pulse rises.
  task automatic do_toggle(input bit clr_at_pulse, input int ena_off);
    exp_t e;
    int   c;
    c = cyc;
    m_level = ~m_level;
    line = m_level;
    if (clr_at_pulse) begin
      m_cnt = 8'h00;
      m_ovf = 1'b0;
    end else if (m_cnt == 8'hFF) begin
      m_ovf = 1'b1;
      m_cnt = sat ? 8'hFF : 8'h00;
    end else begin
      m_cnt = m_cnt + 8'h01;
    end
    e.at_cyc = c + 6 + ena_off;
    e.cnt    = m_cnt;
    e.uo     = {5'b0, m_ovf, m_level, 1'b1};
    exp_q.push_back(e);
    repeat (4) @(negedge clk);
    if (ena_off > 0) begin
      ena = 1'b0;
      repeat (ena_off) @(negedge clk);
      ena = 1'b1;
    end
    @(negedge clk);
    if (clr_at_pulse) clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic do_clear();
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    clr = 1'b0;
    m_cnt = 8'h00;
    m_ovf = 1'b0;
    chk("clear_count", 16'(uio_out), 16'h00);
    chk("clear_ovf", 16'(uo_out[2]), 16'h0);
  endtask

  initial begin
    int c;
    #1;
    chk("reset_uo", 16'(uo_out), 16'h00);
    chk("reset_uio_out", 16'(uio_out), 16'h00);
    chk("reset_uio_oe", 16'(uio_oe), 16'hFF);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // Quiet line: nothing but the idle flag after 10 cycles.
    repeat (9) @(negedge clk);
    chk("quiet_uo_9", 16'(uo_out), 16'h00);
    chk("quiet_count", 16'(uio_out), 16'h00);
    @(negedge clk);
    chk("idle_at_10", 16'(uo_out), 16'h08);

    // First toggle: latency and level timing.
    c = cyc;
    m_level = 1'b1;
    line = 1'b1;
    m_cnt = 8'h01;
    exp_q.push_back('{at_cyc: c + 6, cnt: 8'h01, uo: 8'h03});
    repeat (5) @(negedge clk);
    chk("before_edge6_uo", 16'(uo_out), 16'h08);
    @(negedge clk);
    @(negedge clk);
    chk("after_pulse_uo", 16'(uo_out), 16'h02);
    repeat (3) @(negedge clk);

    // 3-cycle glitch must be rejected.
    line = 1'b0;
    repeat (3) @(negedge clk);
    line = 1'b1;
    repeat (10) @(negedge clk);
    chk("glitch_count", 16'(uio_out), 16'h01);
    chk("glitch_level", 16'(uo_out[1]), 16'h1);

    // Wrap mode: 256 toggles from 0 wrap back to 0 with overflow.
    sat = 1'b0;
    do_clear();
    for (int i = 0; i < 256; i++) do_toggle(1'b0, 0);
    chk("wrap_count", 16'(uio_out), 16'h00);
    chk("wrap_ovf", 16'(uo_out[2]), 16'h1);

    // Saturate mode: 256 toggles from 0 stick at 0xFF.
    sat = 1'b1;
    do_clear();
    for (int i = 0; i < 256; i++) do_toggle(1'b0, 0);
    chk("sat_count", 16'(uio_out), 16'hFF);
    chk("sat_ovf", 16'(uo_out[2]), 16'h1);
    do_clear();

    // Clear coinciding with a pulse, then a 5-cycle ena drop mid-QUALIFY.
    do_toggle(1'b0, 0);
    do_toggle(1'b1, 0);
    chk("clr_pulse_count", 16'(uio_out), 16'h00);
    do_toggle(1'b0, 5);
    chk("ena_drop_count", 16'(uio_out), 16'h01);

    // Idle reasserts after 10 quiet cycles, then clears on the next pulse.
    repeat (12) @(negedge clk);
    chk("idle_again", 16'(uo_out[3]), 16'h1);
    do_toggle(1'b0, 0);
    chk("idle_cleared", 16'(uo_out[3]), 16'h0);

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 16'(exp_q.size()), 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
